// File: rtl/quicklogic_pipe_alu_if.sv
// Streaming operand/result bundle for quicklogic_pipe_alu.
// The master drives operands and result backpressure, and the slave (the adder) drives everything else.
interface quicklogic_pipe_alu_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x;
    logic             co;
    logic             ov;

    modport master (
        output in_valid, a, b, bi, ci, out_ready,
        input  in_ready, out_valid, y, x, co, ov
    );

    modport slave (
        input  in_valid, a, b, bi, ci, out_ready,
        output in_ready, out_valid, y, x, co, ov
    );
endinterface

// File: rtl/quicklogic_pipe_alu.sv
// Pipelined add/subtract unit. The WIDTH-bit ripple carry chain is cut into SEG_W-bit segments with a register between them.
// Lower result bits travel forward with the beat so that every bit reaches the output in the same cycle.
module quicklogic_pipe_alu #(
    parameter int WIDTH  = 16,
    parameter int SEG_W  = 4,
    parameter int SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    quicklogic_pipe_alu_if.slave   bus
);
    localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;
    // The last stage consumes its operands in place, so only NSEG-1 operand registers exist.
    localparam int NOP  = (NSEG > 1) ? (NSEG - 1) : 1;

    logic                             adv_s;
    logic [WIDTH-1:0]                 b_in_s;
    logic [NSEG-1:0]                  valid_r;
    logic [NSEG-1:0]                  carry_r;
    logic [NSEG-1:0]                  carry_s;
    logic [NSEG-1:0][WIDTH-1:0]       sum_r;
    logic [NSEG-1:0][WIDTH-1:0]       sum_s;
    logic [NSEG-1:0][WIDTH-1:0]       x_r;
    logic [NSEG-1:0][WIDTH-1:0]       x_s;
    logic [NSEG-1:0][WIDTH-1:0]       a_s;
    logic [NSEG-1:0][WIDTH-1:0]       b_s;
    logic [NOP-1:0][WIDTH-1:0]        a_r;
    logic [NOP-1:0][WIDTH-1:0]        b_r;
    logic                             ov_r;
    logic                             ov_s;

    assign adv_s         = ~valid_r[NSEG-1] | bus.out_ready;
    assign bus.in_ready  = adv_s;
    assign bus.out_valid = valid_r[NSEG-1];
    assign bus.y         = sum_r[NSEG-1];
    assign bus.x         = x_r[NSEG-1];
    assign bus.co        = carry_r[NSEG-1];
    assign bus.ov        = ov_r;

    // Per-stage segment ripple: each stage adds its own slice onto the sum carried in from the previous stage.
    always_comb begin
        logic c_s;
        logic in_seg_s;
        int   kp;
        b_in_s   = bus.bi ? ~bus.b : bus.b;
        sum_s    = '0;
        x_s      = '0;
        a_s      = '0;
        b_s      = '0;
        carry_s  = '0;
        c_s      = 1'b0;
        in_seg_s = 1'b0;
        kp       = 0;
        ov_s     = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            kp = (k > 0) ? (k - 1) : 0;
            if (k == 0) begin
                a_s[k] = bus.a;
                b_s[k] = b_in_s;
                c_s    = bus.ci;
            end else begin
                a_s[k]   = a_r[kp];
                b_s[k]   = b_r[kp];
                sum_s[k] = sum_r[kp];
                x_s[k]   = x_r[kp];
                c_s      = carry_r[kp];
            end
            for (int i = 0; i < WIDTH; i++) begin
                in_seg_s    = (i >= k * SEG_W) && (i < (k + 1) * SEG_W);
                sum_s[k][i] = in_seg_s ? (a_s[k][i] ^ b_s[k][i] ^ c_s) : sum_s[k][i];
                x_s[k][i]   = in_seg_s ? (a_s[k][i] ^ b_s[k][i]) : x_s[k][i];
                c_s         = in_seg_s ? ((a_s[k][i] & b_s[k][i]) | (c_s & (a_s[k][i] ^ b_s[k][i]))) : c_s;
            end
            carry_s[k] = c_s;
        end
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        if (SIGNED != 0) begin
            ov_s = sum_s[NSEG-1][WIDTH-1] ^ a_s[NSEG-1][WIDTH-1]
                 ^ b_s[NSEG-1][WIDTH-1] ^ carry_s[NSEG-1];
        end else begin
            ov_s = 1'b0;
        end
    end

    // Pipeline registers advance together; the whole pipe freezes under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            carry_r <= '0;
            sum_r   <= '0;
            x_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            ov_r    <= 1'b0;
        end else if (adv_s) begin
            valid_r[0] <= bus.in_valid;
            for (int k = 1; k < NSEG; k++) begin
                valid_r[k] <= valid_r[k-1];
            end
            for (int k = 0; k < NSEG - 1; k++) begin
                a_r[k] <= a_s[k];
                b_r[k] <= b_s[k];
            end
            carry_r <= carry_s;
            sum_r   <= sum_s;
            x_r     <= x_s;
            ov_r    <= ov_s;
        end
    end
endmodule

// File: tb/tb_quicklogic_pipe_alu.sv
// Bench for quicklogic_pipe_alu: a 16/4 signed instance and a 10/4 unsigned instance.
// Each DUT has a scoreboard queue that is filled on accept and drained on result pop.
module tb_quicklogic_pipe_alu;
    typedef struct {
        logic [15:0] y;
        logic [15:0] x;
        logic        co;
        logic        ov;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quicklogic_pipe_alu_if #(.WIDTH(16)) bus0 ();
    quicklogic_pipe_alu_if #(.WIDTH(10)) bus1 ();

    quicklogic_pipe_alu #(.WIDTH(16), .SEG_W(4), .SIGNED(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    quicklogic_pipe_alu #(.WIDTH(10), .SEG_W(4), .SIGNED(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t held[2];
    exp_t last_out[2];
    bit   held_v[2];
    int   sent[2];
    int   rcvd[2];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   lat_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic sgn, input logic [15:0] a,
                                   input logic [15:0] b, input logic bi, input logic ci);
        exp_t        m;
        logic [16:0] full;
        logic [15:0] mask;
        logic [15:0] ar;
        logic [15:0] be;
        mask = 16'hFFFF >> (16 - w);
        ar   = a & mask;
        be   = (bi ? ~b : b) & mask;
        full = {1'b0, ar} + {1'b0, be} + {16'd0, ci};
        m.y  = full[15:0] & mask;
        m.co = full[w];
        m.x  = (ar ^ be) & mask;
        m.ov = sgn && (ar[w-1] == be[w-1]) && (m.y[w-1] != ar[w-1]);
        m.acc = 0;
        m.lat = 1'b0;
        return m;
    endfunction

    task automatic drv(input int d, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic bi, input logic ci, input logic ordy);
        if (d == 0) begin
            bus0.in_valid = v; bus0.a = a; bus0.b = b; bus0.bi = bi; bus0.ci = ci; bus0.out_ready = ordy;
        end else begin
            bus1.in_valid = v; bus1.a = a[9:0]; bus1.b = b[9:0]; bus1.bi = bi; bus1.ci = ci; bus1.out_ready = ordy;
        end
    endtask

    task automatic service(input int d);
        exp_t        o;
        exp_t        e;
        logic        ovld, ordy, irdy, ivld, ibi, ici;
        logic [15:0] ia, ib;
        int          w;
        int          nseg;
        if (d == 0) begin
            ovld = bus0.out_valid; ordy = bus0.out_ready; irdy = bus0.in_ready; ivld = bus0.in_valid;
            o.y = bus0.y; o.x = bus0.x; o.co = bus0.co; o.ov = bus0.ov;
            ia = bus0.a; ib = bus0.b; ibi = bus0.bi; ici = bus0.ci; w = 16; nseg = 4;
        end else begin
            ovld = bus1.out_valid; ordy = bus1.out_ready; irdy = bus1.in_ready; ivld = bus1.in_valid;
            o.y = {6'd0, bus1.y}; o.x = {6'd0, bus1.x}; o.co = bus1.co; o.ov = bus1.ov;
            ia = {6'd0, bus1.a}; ib = {6'd0, bus1.b}; ibi = bus1.bi; ici = bus1.ci; w = 10; nseg = 3;
        end
        if (held_v[d]) begin
            chk("hold_valid", {31'd0, ovld}, 32'd1);
            chk("hold_y", {16'd0, o.y}, {16'd0, held[d].y});
            chk("hold_x", {16'd0, o.x}, {16'd0, held[d].x});
            chk("hold_co", {31'd0, o.co}, {31'd0, held[d].co});
            chk("hold_ov", {31'd0, o.ov}, {31'd0, held[d].ov});
        end
        if (ovld && ordy) begin
            if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                chk("unexpected_out", {31'd0, ovld}, 32'd0);
            end else begin
                e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                chk("y", {16'd0, o.y}, {16'd0, e.y});
                chk("x", {16'd0, o.x}, {16'd0, e.x});
                chk("co", {31'd0, o.co}, {31'd0, e.co});
                chk("ov", {31'd0, o.ov}, {31'd0, e.ov});
                if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(nseg));
            end
            last_out[d] = o;
            rcvd[d]++;
        end
        if (ovld && !ordy) begin
            chk("in_ready_stall", {31'd0, irdy}, 32'd0);
            held_v[d] = 1'b1;
            held[d]   = o;
        end else begin
            held_v[d] = 1'b0;
        end
        if (ivld && irdy) begin
            e     = model(w, (d == 0), ia, ib, ibi, ici);
            e.acc = cyc;
            e.lat = lat_chk;
            if (d == 0) sb0.push_back(e); else sb1.push_back(e);
            sent[d]++;
        end
    endtask

    task automatic step();
        #1;
        service(0);
        service(1);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_wait(input int d, input logic [15:0] a, input logic [15:0] b,
                             input logic bi, input logic ci);
        int r0;
        r0 = rcvd[d];
        lat_chk = 1'b1;
        drv(d, 1'b1, a, b, bi, ci, 1'b1);
        step();
        drv(d, 1'b0, a, b, bi, ci, 1'b1);
        for (int j = 0; j < 12 && rcvd[d] == r0; j++) step();
        lat_chk = 1'b0;
        chk("single_rx", 32'(rcvd[d] - r0), 32'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid0", {31'd0, bus0.out_valid}, 32'd0);
        chk("rst_y0", {16'd0, bus0.y}, 32'd0);
        chk("rst_x0", {16'd0, bus0.x}, 32'd0);
        chk("rst_co0", {31'd0, bus0.co}, 32'd0);
        chk("rst_ov0", {31'd0, bus0.ov}, 32'd0);
        chk("rst_out_valid1", {31'd0, bus1.out_valid}, 32'd0);
        chk("rst_y1", {22'd0, bus1.y}, 32'd0);
    endtask

    initial begin
        int s0, r0, s1, r1;
        rst = 1'b1;
        drv(0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        drv(1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        held_v[0] = 1'b0; held_v[1] = 1'b0;
        sent[0] = 0; sent[1] = 0; rcvd[0] = 0; rcvd[1] = 0;
        @(posedge clk);
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Wrap-around add and subtraction with borrow.
        send_wait(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("t1_y", {16'd0, last_out[0].y}, 32'h0000);
        chk("t1_x", {16'd0, last_out[0].x}, 32'hFFFE);
        chk("t1_co", {31'd0, last_out[0].co}, 32'd1);
        send_wait(0, 16'h0005, 16'h0007, 1'b1, 1'b1);
        chk("t2_y", {16'd0, last_out[0].y}, 32'hFFFE);
        chk("t2_co", {31'd0, last_out[0].co}, 32'd0);
        send_wait(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("t2s_y", {16'd0, last_out[0].y}, 32'h8000);
        chk("t2s_ov", {31'd0, last_out[0].ov}, 32'd1);
        chk("t2s_co", {31'd0, last_out[0].co}, 32'd0);

        // Narrower top segment on the 10-bit instance.
        send_wait(1, 16'h03FF, 16'h0001, 1'b0, 1'b0);
        chk("t5_y", {16'd0, last_out[1].y}, 32'h0000);
        chk("t5_co", {31'd0, last_out[1].co}, 32'd1);

        // Back-to-back stream with a 4-cycle output stall.
        s0 = sent[0]; r0 = rcvd[0];
        for (int j = 0; j < 40 && (rcvd[0] - r0) < 8; j++) begin
            drv(0, (sent[0] - s0) < 8, 16'(sent[0] - s0), 16'(sent[0] - s0 + 1), 1'b0, 1'b0,
                !(j >= 6 && j <= 9));
            step();
        end
        drv(0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        chk("stream_rx", 32'(rcvd[0] - r0), 32'd8);
        chk("stream_sb_empty", 32'(sb0.size()), 32'd0);

        // Reset with three beats in flight.
        for (int j = 0; j < 3; j++) begin
            drv(0, 1'b1, 16'(16'h0100 + j), 16'h0011, 1'b0, 1'b1, 1'b1);
            step();
        end
        drv(0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        sb0.delete(); sb1.delete();
        held_v[0] = 1'b0; held_v[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_wait(0, 16'h1234, 16'h4321, 1'b0, 1'b0);

        // Random traffic with random backpressure on both instances.
        s0 = sent[0]; r0 = rcvd[0]; s1 = sent[1]; r1 = rcvd[1];
        for (int j = 0; j < 60000; j++) begin
            if ((rcvd[0] - r0) >= 10000 && (rcvd[1] - r1) >= 10000) break;
            for (int d = 0; d < 2; d++) begin
                drv(d, ((sent[d] - ((d == 0) ? s0 : s1)) < 10000) && ($urandom_range(0, 3) != 0),
                    16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0);
            end
            step();
        end
        chk("rand_rx0", 32'(rcvd[0] - r0), 32'd10000);
        chk("rand_rx1", 32'(rcvd[1] - r1), 32'd10000);
        chk("rand_sb0_empty", 32'(sb0.size()), 32'd0);
        chk("rand_sb1_empty", 32'(sb1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
